wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stage (requester A) and the long-latency mult/div/late-result path (requester B). A has priority; B results are held in a small FIFO and drained in idle cycles or forcibly after a bounded wait, in which case A is stalled for one cycle. The block sits between writeback and the regfile write port, and exports a pending-register mask so the hazard unit can interlock readers and same-register writers.

## Interface
- DEPTH, 2: B FIFO entries; power of two, 2..8.
- MAX_WAIT, 4: consecutive A grants tolerated while B is non-empty before B is forced; 1..15.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a_valid  in  1  writeback stage has a regfile write this cycle.
- a_id  in  5  destination register.
- a_data  in  32  write data.
- a_ready  out  1  A accepted this cycle; low stalls writeback (hazard unit).
- b_valid  in  1  late unit offers a result.
- b_id  in  5  destination register.
- b_data  in  32  result data.
- b_ready  out  1  FIFO can accept; push = b_valid & b_ready.
- rf_valid  out  1  registered regfile write enable.
- rf_id  out  5  registered write id.
- rf_data  out  32  registered write data.
- pend_mask  out  32  bit i set iff a FIFO entry targets register i; bit 0 always 0.
- b_count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: circular, head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- b_ready = (count < DEPTH), from pre-pop count; no push when full even if a pop occurs the same cycle.
- Push with b_id == 0: accepted (b_ready honoured), not stored, count unchanged.
- force = (count != 0) && (wait_cnt == MAX_WAIT).
- Grant, combinational, priority order:
  - force: grant B (pop head); a_ready = 0.
  - else a_valid: grant A; a_ready = 1.
  - else count != 0: grant B (pop head); a_ready = 1.
  - else no grant; a_ready = 1.
- a_ready depends only on force, never on a_valid.
- wait_cnt (4 bits): cleared when B granted or count == 0 (after update); incremented, saturating at MAX_WAIT, when A granted and count != 0.
- Output register: rf_valid <= grant && granted id != 0; rf_id/rf_data <= granted request (hold previous values when no grant). A write to id 0 is consumed with rf_valid = 0.
- Pop and push in the same cycle: both happen; count unchanged; popped entry is the old head (a pushed entry is never bypassed to the output in its push cycle).
- pend_mask: OR of one-hot decodes of all valid entries (duplicates allowed); from current state, excludes same-cycle push, includes entry being popped.
- Ordering between A and B to the same register is not resolved here; hazard unit uses pend_mask.

## Timing
- Reset values: rf_valid 0, rf_id 0, rf_data 0, pend_mask 0, b_count 0, wait_cnt 0; combinational a_ready 1, b_ready 1.
- Latency: granted request appears on rf_* the next rising edge (1 cycle); FIFO entry earliest on rf_* 2 cycles after push.
- Max B wait with A continuously valid: MAX_WAIT A grants then one forced B grant.
- Reset mid-operation: FIFO contents discarded immediately; no rf_valid pulse after reset deasserts until a new grant.

## Test plan
- Reset, idle: a_valid=0, b_valid=0 -> a_ready=1, b_ready=1, rf_valid=0, pend_mask=0 for all cycles.
- A only: a_valid=1, a_id=5, a_data=0x1234 -> next cycle rf_valid=1, rf_id=5, rf_data=0x1234; a_id=0 -> rf_valid=0, a_ready=1.
- B into idle: push b_id=3, data 0xAA -> pend_mask=0x8 next cycle, rf_id=3/rf_data=0xAA one cycle later, pend_mask back to 0.
- Starvation, MAX_WAIT=4: one B entry, a_valid held 1 -> four A writes, then a_ready=0 for exactly one cycle, B written, A resumes.
- Full FIFO, DEPTH=2: push ids 7, 9 while A busy -> b_ready=0, b_count=2, pend_mask=0x280; third b_valid held until a pop, then accepted next cycle.
- Async reset with 2 entries pending -> b_count=0, pend_mask=0, rf_valid=0 immediately; no stale write afterwards.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback stage, the late-result path and the
// register-file write port. The arbiter connects through the slave modport;
// the surrounding pipeline (or a bench) uses the master modport.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic [4:0]    a_id;
    logic [31:0]   a_data;
    logic          a_ready;

    logic          b_valid;
    logic [4:0]    b_id;
    logic [31:0]   b_data;
    logic          b_ready;

    logic          rf_valid;
    logic [4:0]    rf_id;
    logic [31:0]   rf_data;

    logic [31:0]   pend_mask;
    logic [CW-1:0] b_count;

    modport slave (
        input  a_valid, a_id, a_data,
        input  b_valid, b_id, b_data,
        output a_ready, b_ready,
        output rf_valid, rf_id, rf_data,
        output pend_mask, b_count
    );

    modport master (
        output a_valid, a_id, a_data,
        output b_valid, b_id, b_data,
        input  a_ready, b_ready,
        input  rf_valid, rf_id, rf_data,
        input  pend_mask, b_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The in-order writeback stage (A) normally
// wins; late results (B) wait in a small circular FIFO and drain in idle
// cycles, or are forced through after MAX_WAIT consecutive A grants, stalling
// A for one cycle. pend_mask tells the hazard unit which registers still have
// a queued late write.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [3:0]    MaxWait   = 4'(MAX_WAIT);

    logic [4:0]    id_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    wait_q, wait_d;
    logic          rf_valid_q, rf_valid_d;
    logic [4:0]    rf_id_q, rf_id_d;
    logic [31:0]   rf_data_q, rf_data_d;

    logic          not_empty;
    logic          force_b;
    logic          grant_a;
    logic          grant_b;
    logic          push;
    logic          store;
    logic [31:0]   pend_mask;

    // Grant decision, FIFO pointer/occupancy update, starvation counter and
    // next value of the registered write port.
    always_comb begin
        not_empty = (count_q != '0);
        force_b   = not_empty && (wait_q == MaxWait);
        grant_b   = force_b || (!bus.a_valid && not_empty);
        grant_a   = !force_b && bus.a_valid;
        push      = bus.b_valid && (count_q < FullCount);
        store     = push && (bus.b_id != 5'd0);

        head_d  = grant_b ? head_q + PW'(1) : head_q;
        tail_d  = store ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(store) - CW'(grant_b);

        wait_d = wait_q;
        if (grant_b || (count_d == '0)) begin
            wait_d = 4'd0;
        end else if (grant_a && not_empty && (wait_q != MaxWait)) begin
            wait_d = wait_q + 4'd1;
        end

        rf_valid_d = 1'b0;
        rf_id_d    = rf_id_q;
        rf_data_d  = rf_data_q;
        if (grant_b) begin
            rf_valid_d = (id_q[head_q] != 5'd0);
            rf_id_d    = id_q[head_q];
            rf_data_d  = data_q[head_q];
        end else if (grant_a) begin
            rf_valid_d = (bus.a_id != 5'd0);
            rf_id_d    = bus.a_id;
            rf_data_d  = bus.a_data;
        end
    end

    // Pending-register mask: every occupied slot, counted from the head,
    // contributes its destination bit; register 0 never needs an interlock.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - head_q} < count_q) begin
                pend_mask[id_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Control state: FIFO pointers, occupancy and starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // FIFO storage: a late result is written at the tail when it is stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (store) begin
            id_q[tail_q]   <= bus.b_id;
            data_q[tail_q] <= bus.b_data;
        end
    end

    // Registered regfile write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_valid_q <= 1'b0;
            rf_id_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            rf_valid_q <= rf_valid_d;
            rf_id_q    <= rf_id_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign bus.a_ready   = !force_b;
    assign bus.b_ready   = (count_q < FullCount);
    assign bus.rf_valid  = rf_valid_q;
    assign bus.rf_id     = rf_id_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.pend_mask = pend_mask;
    assign bus.b_count   = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4). Each scenario is a table of
// cycles with the grant the arbitration rules call for; expected regfile
// writes go into a scoreboard queue as stimulus is driven and are popped when
// the DUT raises rf_valid. Late results are tracked in a model FIFO so the
// scoreboard learns which entry a B grant must deliver.
module tb_wb_port_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int GNONE    = 0;
    localparam int GA       = 1;
    localparam int GB       = 2;

    typedef struct {
        bit          av;
        logic [4:0]  aid;
        logic [31:0] ad;
        bit          bv;
        logic [4:0]  bid;
        logic [31:0] bd;
        bit          ear;
        bit          ebr;
        int          g;
        int          ecnt;
        logic [31:0] epend;
    } cyc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb [$];
    logic [36:0] bq [$];

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic cyc_t row(bit av, logic [4:0] aid, logic [31:0] ad,
                                 bit bv, logic [4:0] bid, logic [31:0] bd,
                                 bit ear, bit ebr, int g, int ecnt, logic [31:0] epend);
        cyc_t r;
        r.av = av;   r.aid = aid; r.ad = ad;
        r.bv = bv;   r.bid = bid; r.bd = bd;
        r.ear = ear; r.ebr = ebr; r.g = g;
        r.ecnt = ecnt; r.epend = epend;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_id = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_id = '0; bus.b_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.rf_valid !== 1'b0 || bus.b_count !== '0 || bus.pend_mask !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got rf_valid=%b b_count=%0d pend=%h expected 0/0/0",
                     bus.rf_valid, bus.b_count, bus.pend_mask);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_idle_ready cyc %0d: got a_ready=%b b_ready=%b expected 1/1",
                         k, bus.a_ready, bus.b_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.rf_valid !== 1'b0 || bus.b_count !== '0 || bus.pend_mask !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_idle_out cyc %0d: got rf_valid=%b b_count=%0d pend=%h expected 0/0/0",
                         k, bus.rf_valid, bus.b_count, bus.pend_mask);
            end
        end
    endtask

    task automatic test_a_only();
        cyc_t rows [$];
        logic [36:0] exp;
        bit expV;
        rows.push_back(row(1, 5,  32'h0000_1234, 0, 0, 0, 1, 1, GA,    0, 0));
        rows.push_back(row(1, 0,  32'h0000_DEAD, 0, 0, 0, 1, 1, GA,    0, 0));
        rows.push_back(row(1, 31, 32'hFFFF_0001, 0, 0, 0, 1, 1, GA,    0, 0));
        rows.push_back(row(1, 10, 32'hCAFE_BABE, 0, 0, 0, 1, 1, GA,    0, 0));
        rows.push_back(row(0, 0,  32'h0,         0, 0, 0, 1, 1, GNONE, 0, 0));
        foreach (rows[k]) begin
            bus.a_valid = rows[k].av; bus.a_id = rows[k].aid; bus.a_data = rows[k].ad;
            bus.b_valid = rows[k].bv; bus.b_id = rows[k].bid; bus.b_data = rows[k].bd;
            if (rows[k].g == GA && rows[k].aid != 5'd0) sb.push_back({rows[k].aid, rows[k].ad});
            #1;
            checks++;
            if (bus.a_ready !== rows[k].ear || bus.b_ready !== rows[k].ebr) begin
                errors++;
                $display("[TB] FAIL a_only row %0d ready: got a=%b b=%b expected a=%b b=%b",
                         k, bus.a_ready, bus.b_ready, rows[k].ear, rows[k].ebr);
            end
            @(posedge clk); #1;
            expV = (rows[k].g == GA && rows[k].aid != 5'd0);
            checks++;
            if (bus.rf_valid !== expV) begin
                errors++;
                $display("[TB] FAIL a_only row %0d rf_valid: got %b expected %b", k, bus.rf_valid, expV);
            end
            if (expV && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.rf_id, bus.rf_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL a_only row %0d rf write: got id=%0d data=%h expected id=%0d data=%h",
                             k, bus.rf_id, bus.rf_data, exp[36:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_b_idle();
        cyc_t rows [$];
        logic [36:0] exp;
        bit expV;
        rows.push_back(row(0, 0, 0, 1, 3, 32'h0000_00AA, 1, 1, GNONE, 1, 32'h8));
        rows.push_back(row(0, 0, 0, 0, 0, 32'h0,         1, 1, GB,    0, 32'h0));
        rows.push_back(row(0, 0, 0, 0, 0, 32'h0,         1, 1, GNONE, 0, 32'h0));
        foreach (rows[k]) begin
            bus.a_valid = rows[k].av; bus.a_id = rows[k].aid; bus.a_data = rows[k].ad;
            bus.b_valid = rows[k].bv; bus.b_id = rows[k].bid; bus.b_data = rows[k].bd;
            if (rows[k].g == GB && bq.size() != 0) sb.push_back(bq.pop_front());
            if (rows[k].bv && rows[k].ebr && rows[k].bid != 5'd0) bq.push_back({rows[k].bid, rows[k].bd});
            #1;
            checks++;
            if (bus.a_ready !== rows[k].ear || bus.b_ready !== rows[k].ebr) begin
                errors++;
                $display("[TB] FAIL b_idle row %0d ready: got a=%b b=%b expected a=%b b=%b",
                         k, bus.a_ready, bus.b_ready, rows[k].ear, rows[k].ebr);
            end
            @(posedge clk); #1;
            expV = (rows[k].g == GB);
            checks++;
            if (bus.rf_valid !== expV) begin
                errors++;
                $display("[TB] FAIL b_idle row %0d rf_valid: got %b expected %b", k, bus.rf_valid, expV);
            end
            if (expV && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.rf_id, bus.rf_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL b_idle row %0d rf write: got id=%0d data=%h expected id=%0d data=%h",
                             k, bus.rf_id, bus.rf_data, exp[36:32], exp[31:0]);
                end
            end
            checks++;
            if (bus.b_count !== rows[k].ecnt[CW-1:0] || bus.pend_mask !== rows[k].epend) begin
                errors++;
                $display("[TB] FAIL b_idle row %0d fifo: got count=%0d pend=%h expected count=%0d pend=%h",
                         k, bus.b_count, bus.pend_mask, rows[k].ecnt, rows[k].epend);
            end
        end
    endtask

    task automatic test_starvation();
        cyc_t rows [$];
        logic [36:0] exp;
        bit expV;
        rows.push_back(row(1, 1, 32'h101, 1, 4, 32'h44, 1, 1, GA, 1, 32'h10));
        for (int a = 2; a <= 5; a++) begin
            rows.push_back(row(1, 5'(a), 32'h100 + 32'(a), 0, 0, 0, 1, 1, GA, 1, 32'h10));
        end
        rows.push_back(row(1, 6, 32'h106, 0, 0, 0, 0, 1, GB,    0, 32'h0));
        rows.push_back(row(1, 6, 32'h106, 0, 0, 0, 1, 1, GA,    0, 32'h0));
        rows.push_back(row(0, 0, 32'h0,   0, 0, 0, 1, 1, GNONE, 0, 32'h0));
        foreach (rows[k]) begin
            bus.a_valid = rows[k].av; bus.a_id = rows[k].aid; bus.a_data = rows[k].ad;
            bus.b_valid = rows[k].bv; bus.b_id = rows[k].bid; bus.b_data = rows[k].bd;
            if (rows[k].g == GA && rows[k].aid != 5'd0) sb.push_back({rows[k].aid, rows[k].ad});
            if (rows[k].g == GB && bq.size() != 0) sb.push_back(bq.pop_front());
            if (rows[k].bv && rows[k].ebr && rows[k].bid != 5'd0) bq.push_back({rows[k].bid, rows[k].bd});
            #1;
            checks++;
            if (bus.a_ready !== rows[k].ear || bus.b_ready !== rows[k].ebr) begin
                errors++;
                $display("[TB] FAIL starvation row %0d ready: got a=%b b=%b expected a=%b b=%b",
                         k, bus.a_ready, bus.b_ready, rows[k].ear, rows[k].ebr);
            end
            @(posedge clk); #1;
            expV = (rows[k].g == GB) || (rows[k].g == GA && rows[k].aid != 5'd0);
            checks++;
            if (bus.rf_valid !== expV) begin
                errors++;
                $display("[TB] FAIL starvation row %0d rf_valid: got %b expected %b", k, bus.rf_valid, expV);
            end
            if (expV && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.rf_id, bus.rf_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL starvation row %0d rf write: got id=%0d data=%h expected id=%0d data=%h",
                             k, bus.rf_id, bus.rf_data, exp[36:32], exp[31:0]);
                end
            end
            checks++;
            if (bus.b_count !== rows[k].ecnt[CW-1:0] || bus.pend_mask !== rows[k].epend) begin
                errors++;
                $display("[TB] FAIL starvation row %0d fifo: got count=%0d pend=%h expected count=%0d pend=%h",
                         k, bus.b_count, bus.pend_mask, rows[k].ecnt, rows[k].epend);
            end
        end
    endtask

    task automatic test_full_fifo();
        cyc_t rows [$];
        logic [36:0] exp;
        bit expV;
        rows.push_back(row(1, 11, 32'hA11, 1, 7,  32'h77,   1, 1, GA,    1, 32'h80));
        rows.push_back(row(1, 12, 32'hA12, 1, 9,  32'h99,   1, 1, GA,    2, 32'h280));
        rows.push_back(row(1, 13, 32'hA13, 1, 20, 32'h2020, 1, 0, GA,    2, 32'h280));
        rows.push_back(row(1, 14, 32'hA14, 1, 20, 32'h2020, 1, 0, GA,    2, 32'h280));
        rows.push_back(row(1, 15, 32'hA15, 1, 20, 32'h2020, 1, 0, GA,    2, 32'h280));
        rows.push_back(row(1, 16, 32'hA16, 1, 20, 32'h2020, 0, 0, GB,    1, 32'h200));
        rows.push_back(row(1, 16, 32'hA16, 1, 20, 32'h2020, 1, 1, GA,    2, 32'h0010_0200));
        rows.push_back(row(0, 0,  32'h0,   0, 0,  32'h0,    1, 0, GB,    1, 32'h0010_0000));
        rows.push_back(row(0, 0,  32'h0,   0, 0,  32'h0,    1, 1, GB,    0, 32'h0));
        rows.push_back(row(0, 0,  32'h0,   0, 0,  32'h0,    1, 1, GNONE, 0, 32'h0));
        foreach (rows[k]) begin
            bus.a_valid = rows[k].av; bus.a_id = rows[k].aid; bus.a_data = rows[k].ad;
            bus.b_valid = rows[k].bv; bus.b_id = rows[k].bid; bus.b_data = rows[k].bd;
            if (rows[k].g == GA && rows[k].aid != 5'd0) sb.push_back({rows[k].aid, rows[k].ad});
            if (rows[k].g == GB && bq.size() != 0) sb.push_back(bq.pop_front());
            if (rows[k].bv && rows[k].ebr && rows[k].bid != 5'd0) bq.push_back({rows[k].bid, rows[k].bd});
            #1;
            checks++;
            if (bus.a_ready !== rows[k].ear || bus.b_ready !== rows[k].ebr) begin
                errors++;
                $display("[TB] FAIL full_fifo row %0d ready: got a=%b b=%b expected a=%b b=%b",
                         k, bus.a_ready, bus.b_ready, rows[k].ear, rows[k].ebr);
            end
            @(posedge clk); #1;
            expV = (rows[k].g == GB) || (rows[k].g == GA && rows[k].aid != 5'd0);
            checks++;
            if (bus.rf_valid !== expV) begin
                errors++;
                $display("[TB] FAIL full_fifo row %0d rf_valid: got %b expected %b", k, bus.rf_valid, expV);
            end
            if (expV && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.rf_id, bus.rf_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL full_fifo row %0d rf write: got id=%0d data=%h expected id=%0d data=%h",
                             k, bus.rf_id, bus.rf_data, exp[36:32], exp[31:0]);
                end
            end
            checks++;
            if (bus.b_count !== rows[k].ecnt[CW-1:0] || bus.pend_mask !== rows[k].epend) begin
                errors++;
                $display("[TB] FAIL full_fifo row %0d fifo: got count=%0d pend=%h expected count=%0d pend=%h",
                         k, bus.b_count, bus.pend_mask, rows[k].ecnt, rows[k].epend);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t rows [$];
        logic [36:0] exp;
        bit expV;
        rows.push_back(row(0, 0, 0, 1, 6, 32'h66,   1, 1, GNONE, 1, 32'h40));
        rows.push_back(row(0, 0, 0, 1, 8, 32'h88,   1, 1, GB,    1, 32'h100));
        rows.push_back(row(0, 0, 0, 1, 0, 32'h5A5A, 1, 1, GB,    0, 32'h0));
        rows.push_back(row(0, 0, 0, 0, 0, 32'h0,    1, 1, GNONE, 0, 32'h0));
        foreach (rows[k]) begin
            bus.a_valid = rows[k].av; bus.a_id = rows[k].aid; bus.a_data = rows[k].ad;
            bus.b_valid = rows[k].bv; bus.b_id = rows[k].bid; bus.b_data = rows[k].bd;
            if (rows[k].g == GB && bq.size() != 0) sb.push_back(bq.pop_front());
            if (rows[k].bv && rows[k].ebr && rows[k].bid != 5'd0) bq.push_back({rows[k].bid, rows[k].bd});
            #1;
            checks++;
            if (bus.a_ready !== rows[k].ear || bus.b_ready !== rows[k].ebr) begin
                errors++;
                $display("[TB] FAIL back_to_back row %0d ready: got a=%b b=%b expected a=%b b=%b",
                         k, bus.a_ready, bus.b_ready, rows[k].ear, rows[k].ebr);
            end
            @(posedge clk); #1;
            expV = (rows[k].g == GB);
            checks++;
            if (bus.rf_valid !== expV) begin
                errors++;
                $display("[TB] FAIL back_to_back row %0d rf_valid: got %b expected %b", k, bus.rf_valid, expV);
            end
            if (expV && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.rf_id, bus.rf_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL back_to_back row %0d rf write: got id=%0d data=%h expected id=%0d data=%h",
                             k, bus.rf_id, bus.rf_data, exp[36:32], exp[31:0]);
                end
            end
            checks++;
            if (bus.b_count !== rows[k].ecnt[CW-1:0] || bus.pend_mask !== rows[k].epend) begin
                errors++;
                $display("[TB] FAIL back_to_back row %0d fifo: got count=%0d pend=%h expected count=%0d pend=%h",
                         k, bus.b_count, bus.pend_mask, rows[k].ecnt, rows[k].epend);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.a_valid = 1'b1; bus.a_id = 5'd2; bus.a_data = 32'hA02;
        bus.b_valid = 1'b1; bus.b_id = 5'd7; bus.b_data = 32'h77;
        @(posedge clk); #1;
        bus.a_id = 5'd3; bus.a_data = 32'hA03;
        bus.b_id = 5'd9; bus.b_data = 32'h99;
        @(posedge clk); #1;
        checks++;
        if (bus.b_count !== 2'd2 || bus.pend_mask !== 32'h280 || bus.rf_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset_setup: got count=%0d pend=%h rf_valid=%b expected 2/280/1",
                     bus.b_count, bus.pend_mask, bus.rf_valid);
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.b_count !== '0 || bus.pend_mask !== 32'h0 || bus.rf_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_now: got count=%0d pend=%h rf_valid=%b expected 0/0/0",
                     bus.b_count, bus.pend_mask, bus.rf_valid);
        end
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset_ready: got a=%b b=%b expected 1/1", bus.a_ready, bus.b_ready);
        end
        bq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rf_valid !== 1'b0 || bus.b_count !== '0 || bus.pend_mask !== 32'h0) begin
                errors++;
                $display("[TB] FAIL async_reset_after cyc %0d: got rf_valid=%b count=%0d pend=%h expected 0/0/0",
                         k, bus.rf_valid, bus.b_count, bus.pend_mask);
            end
        end
    endtask

    // Run the scenarios in order and report.
    initial begin
        test_reset();
        test_a_only();
        test_b_idle();
        test_starvation();
        test_full_fifo();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d writes outstanding expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
